reg_cmd_ctrl: RTL

- Initiator side of the 8-bit register-file access interface (WrEn/RdEn/Address/WrData in, RdData/RdData_VLD back).
- Parses byte-serial commands from the UART receive path and issues single-cycle write or read strobes to the register file.
- Captures read data and forwards it to the UART transmit path.
- Sits in the system-control domain, between the RX/TX byte interfaces and the register file.

---
 rtl/reg_cmd_pkg.sv | 22 ++
 rtl/reg_cmd_timer.sv | 35 +++
 rtl/reg_cmd_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/reg_cmd_pkg.sv
// Shared definitions for the register-command controller.
//   state_t      : controller FSM states
//   *_DEF        : default opcode / error byte values used as parameter defaults
//   TIMER_W      : width of the read-timeout counter (covers TIMEOUT up to 255)
package reg_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  localparam logic [7:0] WR_CMD_DEF   = 8'hAA;
  localparam logic [7:0] RD_CMD_DEF   = 8'hBB;
  localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;
  localparam int         TIMEOUT_DEF  = 8;
  localparam int         TIMER_W      = 8;

endpackage

// File: rtl/reg_cmd_timer.sv
// Loadable up-counter with a terminal flag, used to bound the wait for read data.
//   CLK      : clock
//   RST      : synchronous active-high reset (count -> 0)
//   load     : load count with load_val (takes priority over counting)
//   load_val : value to load
//   en       : count up by one per cycle; counting stops once term is reached
//   term     : high while count equals LIMIT
module reg_cmd_timer #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             term
);

  logic [CNT_W-1:0] count_reg;

  assign term = (count_reg == CNT_W'(LIMIT));

  // Holding at LIMIT keeps term asserted instead of wrapping back to zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && !term) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Register-file command controller. Parses byte-serial write/read commands from
// the UART receive path, drives single-cycle register-file strobes, and returns
// read data (or an error byte) on the UART transmit path.
//   CLK, RST              : clock, synchronous active-high reset
//   RX_P_DATA, RX_D_VLD   : received byte and its one-cycle valid
//   WrEn, RdEn            : register-file write / read strobes (one cycle each)
//   Address, WrData       : register-file address and write data
//   RdData, RdData_VLD    : register-file read data and its valid
//   TX_P_DATA, TX_D_VLD   : byte to transmit and its one-cycle request
//   TX_Busy               : transmitter busy, holds off TX_D_VLD
//   Busy                  : high while a command is in progress
// Command formats: WR_CMD, addr, data  /  RD_CMD, addr.
// Every output comes straight from a flop.
module reg_cmd_ctrl
  import reg_cmd_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               ADDR     = 4,
  parameter int               DEPTH    = 16,
  parameter logic [WIDTH-1:0] WR_CMD   = WR_CMD_DEF,
  parameter logic [WIDTH-1:0] RD_CMD   = RD_CMD_DEF,
  parameter logic [WIDTH-1:0] ERR_BYTE = ERR_BYTE_DEF,
  parameter int               TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  input  logic             TX_Busy,
  output logic             Busy
);

  state_t           state_reg, state_next;
  logic             wr_en_reg, wr_en_next;
  logic             rd_en_reg, rd_en_next;
  logic [ADDR-1:0]  address_reg, address_next;
  logic [WIDTH-1:0] wr_data_reg, wr_data_next;
  logic [WIDTH-1:0] tx_data_reg, tx_data_next;
  logic             tx_vld_reg, tx_vld_next;
  logic             busy_reg, busy_next;

  logic addr_ok;
  logic timer_load;
  logic timer_en;
  logic timer_term;

  // Full-byte compare so out-of-range addresses are caught before truncation.
  assign addr_ok = (RX_P_DATA < WIDTH'(DEPTH));

  // The timer is cleared on the edge that raises RdEn, so it reads 0 during the
  // RdEn cycle and counts while the controller waits for read data.
  assign timer_en = (state_reg == RD_WAIT);

  reg_cmd_timer #(
    .CNT_W (TIMER_W),
    .LIMIT (TIMEOUT)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (timer_load),
    .load_val ('0),
    .en       (timer_en),
    .term     (timer_term)
  );

  always_comb begin
    state_next   = state_reg;
    wr_en_next   = 1'b0;
    rd_en_next   = 1'b0;
    address_next = address_reg;
    wr_data_next = wr_data_reg;
    tx_data_next = tx_data_reg;
    tx_vld_next  = 1'b0;
    timer_load   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_next = WR_ADDR;
          end else if (RX_P_DATA == RD_CMD) begin
            state_next = RD_ADDR;
          end
        end
      end

      WR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            address_next = RX_P_DATA[ADDR-1:0];
            state_next   = WR_DATA;
          end else begin
            state_next = IDLE;
          end
        end
      end

      WR_DATA: begin
        // Returning to IDLE together with the strobe lets the next opcode land
        // in the WrEn cycle.
        if (RX_D_VLD) begin
          wr_data_next = RX_P_DATA;
          wr_en_next   = 1'b1;
          state_next   = IDLE;
        end
      end

      RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            address_next = RX_P_DATA[ADDR-1:0];
            rd_en_next   = 1'b1;
            timer_load   = 1'b1;
            state_next   = RD_WAIT;
          end else begin
            tx_data_next = ERR_BYTE;
            state_next   = TX_SEND;
          end
        end
      end

      RD_WAIT: begin
        // Data is checked first so it wins a tie with the timeout.
        if (RdData_VLD) begin
          tx_data_next = RdData;
          state_next   = TX_SEND;
        end else if (timer_term) begin
          tx_data_next = ERR_BYTE;
          state_next   = TX_SEND;
        end
      end

      TX_SEND: begin
        if (!TX_Busy) begin
          tx_vld_next = 1'b1;
          state_next  = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      wr_en_reg   <= 1'b0;
      rd_en_reg   <= 1'b0;
      address_reg <= '0;
      wr_data_reg <= '0;
      tx_data_reg <= '0;
      tx_vld_reg  <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wr_en_reg   <= wr_en_next;
      rd_en_reg   <= rd_en_next;
      address_reg <= address_next;
      wr_data_reg <= wr_data_next;
      tx_data_reg <= tx_data_next;
      tx_vld_reg  <= tx_vld_next;
      busy_reg    <= busy_next;
    end
  end

  assign WrEn      = wr_en_reg;
  assign RdEn      = rd_en_reg;
  assign Address   = address_reg;
  assign WrData    = wr_data_reg;
  assign TX_P_DATA = tx_data_reg;
  assign TX_D_VLD  = tx_vld_reg;
  assign Busy      = busy_reg;

endmodule
